// File: rtl/denise_plane_serializer.sv
// Bitplane serializer: per-plane holding registers feed 16-bit shifters whose
// MSBs form a colour select, optionally delayed through a scroll delay line.
module denise_plane_serializer #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        data_wr,
    input  logic [2:0]  plane_sel,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        hires,
    input  logic        shres,
    input  logic [3:0]  nplanes,
    input  logic [3:0]  scroll,
    output logic [7:0]  select
);

    function automatic logic [3:0] sat_nplanes(input logic [3:0] n);
        return (n > 4'd8) ? 4'd8 : n;
    endfunction

    function automatic logic [15:0] shift_left(input logic [15:0] w);
        return {w[14:0], 1'b0};
    endfunction

    logic [1:0]  p;
    logic        phase_stall;
    logic        shift_en;
    logic        load_en;
    logic        wr_en;
    logic [3:0]  nplanes_eff;
    logic [15:0] holding [8];
    logic [15:0] shifter [8];
    logic [7:0]  raw_pixel;
    logic [7:0]  delay_line [DEPTH];
    logic [7:0]  tap;

    assign load_en = load && clk7_en;
    assign wr_en   = data_wr && clk7_en;

    // Phase counter: realigned by every clk7_en; parks at 3 if clk7_en stops
    always_ff @(posedge clk) begin
        if (reset) begin
            p <= 2'd0;
        end else if (clk7_en) begin
            p <= 2'd0;
        end else if (p != 2'd3) begin
            p <= p + 2'd1;
        end
    end

    // In steady state p==3 always coincides with clk7_en, so a missing
    // enable at p==3 means the 7MHz phase has stalled.
    always_comb begin
        phase_stall = (p == 2'd3) && !clk7_en;
        shift_en    = 1'b0;
        if (shres) begin
            shift_en = 1'b1;
        end else if (hires) begin
            shift_en = p[0] && !phase_stall;
        end else begin
            shift_en = (p == 2'd3) && !phase_stall;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 8; n++) holding[n] <= 16'h0000;
        end else if (wr_en) begin
            holding[plane_sel] <= data_in;
        end
    end

    // Load reads the pre-write holding value, so a same-edge write stays queued
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 8; n++) shifter[n] <= 16'h0000;
        end else if (load_en) begin
            for (int n = 0; n < 8; n++) shifter[n] <= holding[n];
        end else if (shift_en) begin
            for (int n = 0; n < 8; n++) shifter[n] <= shift_left(shifter[n]);
        end
    end

    always_comb begin
        nplanes_eff = sat_nplanes(nplanes);
        raw_pixel   = 8'h00;
        for (int n = 0; n < 8; n++) begin
            raw_pixel[n] = shifter[n][15] && (n < int'(nplanes_eff));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) delay_line[k] <= 8'h00;
        end else if (shift_en) begin
            delay_line[0] <= raw_pixel;
            for (int k = 1; k < DEPTH; k++) delay_line[k] <= delay_line[k-1];
        end
    end

    always_comb begin
        tap = 8'h00;
        if (scroll == 4'd0) begin
            tap = raw_pixel;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (int'(scroll) == k + 1) tap = delay_line[k];
            end
        end
    end

    // Output stage: one register between tap and the colour table
    always_ff @(posedge clk) begin
        if (reset) begin
            select <= 8'h00;
        end else begin
            select <= tap;
        end
    end

endmodule
